// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: decodes 10-bit symbols to data/control and hunts for word alignment
// by requesting single-bit slips until control tokens land on symbol boundaries.
module tmds_channel_decoder #(
    parameter int pLockTokens    = 8,
    parameter int pSearchTimeout = 1024,
    parameter int pSlipWait      = 16
) (
    input  logic       iPixelClk,
    input  logic       iRst,
    input  logic [9:0] iSymbol,
    output logic [7:0] oData,
    output logic [1:0] oCtrl,
    output logic       oDe,
    output logic       oAligned,
    output logic       oBitSlip
);

    localparam int tokW  = $clog2(pLockTokens) + 1;
    localparam int idleW = $clog2(pSearchTimeout) + 1;
    localparam int slipW = $clog2(pSlipWait) + 1;

    localparam logic [tokW-1:0]  tokMax  = tokW'(pLockTokens);
    localparam logic [idleW-1:0] idleMax = idleW'(pSearchTimeout);
    localparam logic [slipW-1:0] slipMax = slipW'(pSlipWait);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_WAIT = 2'd1,
        LOCKED    = 2'd2
    } stateT;

    stateT            state, stateNext;
    logic [tokW-1:0]  tokCnt, tokCntNext;
    logic [idleW-1:0] idleCnt, idleCntNext;
    logic [slipW-1:0] slipCnt, slipCntNext;

    logic [9:0] symbol_p1;
    logic       isToken;
    logic [1:0] tokenVal;
    logic [7:0] decoded;
    logic [7:0] dataNext;
    logic [1:0] ctrlNext;
    logic       deNext;
    logic       alignedNext;
    logic       bitSlipNext;

    function automatic logic [tokW-1:0] satIncTok(input logic [tokW-1:0] v);
        return (v >= tokMax) ? tokMax : v + 1'b1;
    endfunction

    function automatic logic [idleW-1:0] satIncIdle(input logic [idleW-1:0] v);
        return (v >= idleMax) ? idleMax : v + 1'b1;
    endfunction

    function automatic logic [slipW-1:0] satIncSlip(input logic [slipW-1:0] v);
        return (v >= slipMax) ? slipMax : v + 1'b1;
    endfunction

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    function automatic logic [7:0] decodeData(input logic [9:0] sym);
        logic [7:0] d;
        logic [7:0] q;
        d    = sym[9] ? ~sym[7:0] : sym[7:0];
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    // Stage 1: capture the raw symbol
    always_ff @(posedge iPixelClk) begin
        symbol_p1 <= iSymbol;
    end

    always_comb begin
        isToken  = 1'b1;
        tokenVal = 2'b00;
        case (symbol_p1)
            10'b1101010100: tokenVal = 2'b00;
            10'b0010101011: tokenVal = 2'b01;
            10'b0101010100: tokenVal = 2'b10;
            10'b1010101011: tokenVal = 2'b11;
            default:        isToken  = 1'b0;
        endcase
        decoded = decodeData(symbol_p1);
    end

    always_ff @(posedge iPixelClk or posedge iRst) begin
        if (iRst) begin
            state   <= SEARCH;
            tokCnt  <= '0;
            idleCnt <= '0;
            slipCnt <= '0;
        end else begin
            state   <= stateNext;
            tokCnt  <= tokCntNext;
            idleCnt <= idleCntNext;
            slipCnt <= slipCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        tokCntNext  = tokCnt;
        idleCntNext = idleCnt;
        slipCntNext = slipCnt;
        case (state)
            SEARCH: begin
                tokCntNext  = isToken ? satIncTok(tokCnt) : '0;
                idleCntNext = isToken ? '0 : satIncIdle(idleCnt);
                // Lock is tested first so it wins over a coincident timeout.
                if (tokCntNext >= tokMax) begin
                    stateNext   = LOCKED;
                    tokCntNext  = '0;
                    idleCntNext = '0;
                end else if (idleCntNext >= idleMax) begin
                    stateNext   = SLIP_WAIT;
                    tokCntNext  = '0;
                    idleCntNext = '0;
                    slipCntNext = '0;
                end
            end
            SLIP_WAIT: begin
                if (slipCnt >= slipMax) begin
                    stateNext   = SEARCH;
                    tokCntNext  = '0;
                    idleCntNext = '0;
                    slipCntNext = '0;
                end else begin
                    slipCntNext = satIncSlip(slipCnt);
                end
            end
            LOCKED: begin
                tokCntNext  = '0;
                idleCntNext = isToken ? '0 : satIncIdle(idleCnt);
                if (idleCntNext >= idleMax) begin
                    stateNext   = SEARCH;
                    idleCntNext = '0;
                end
            end
            default: begin
                stateNext   = SEARCH;
                tokCntNext  = '0;
                idleCntNext = '0;
                slipCntNext = '0;
            end
        endcase
    end

    // Gating follows the state being entered, so the locking token is already shown aligned.
    always_comb begin
        alignedNext = (stateNext == LOCKED);
        bitSlipNext = (state == SEARCH) && (stateNext == SLIP_WAIT);
        dataNext    = oData;
        ctrlNext    = oCtrl;
        deNext      = 1'b0;
        if (!alignedNext) begin
            dataNext = '0;
            ctrlNext = '0;
        end else if (isToken) begin
            ctrlNext = tokenVal;
        end else begin
            dataNext = decoded;
            deNext   = 1'b1;
        end
    end

    // Stage 2: registered outputs
    always_ff @(posedge iPixelClk or posedge iRst) begin
        if (iRst) begin
            oData    <= '0;
            oCtrl    <= '0;
            oDe      <= 1'b0;
            oAligned <= 1'b0;
            oBitSlip <= 1'b0;
        end else begin
            oData    <= dataNext;
            oCtrl    <= ctrlNext;
            oDe      <= deNext;
            oAligned <= alignedNext;
            oBitSlip <= bitSlipNext;
        end
    end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench: a reference TMDS encoder makes stimulus, a behavioural receiver model
// predicts outputs, and a monitor compares them two edges after each symbol is driven.
module tb_tmds_channel_decoder;

    localparam int LOCK     = 8;
    localparam int TIMEOUT  = 1024;
    localparam int SLIPWAIT = 16;
    localparam logic [9:0] HELD = 10'b0100000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sym;
    logic [7:0] oData;
    logic [1:0] oCtrl;
    logic       oDe, oAligned, oBitSlip;

    always #5 clk = ~clk;

    tmds_channel_decoder #(
        .pLockTokens(LOCK), .pSearchTimeout(TIMEOUT), .pSlipWait(SLIPWAIT)
    ) dut (
        .iPixelClk(clk), .iRst(rst), .iSymbol(sym),
        .oData(oData), .oCtrl(oCtrl), .oDe(oDe), .oAligned(oAligned), .oBitSlip(oBitSlip)
    );

    typedef struct {
        int         due;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
        logic       aligned;
        logic       slip;
    } expT;

    expT expQ[$];
    int  cyc = 0;
    int  nTests = 0;
    int  nFail = 0;

    logic [9:0] tokTab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

    // Receiver model: mode 0 = hunting, 1 = waiting after a slip, 2 = locked.
    int         mMode, mTok, mIdle, mWait;
    logic [7:0] mData;
    logic [1:0] mCtrl;
    int         disp;

    task automatic modelReset();
        mMode = 0; mTok = 0; mIdle = 0; mWait = 0;
        mData = 8'h00; mCtrl = 2'b00;
    endtask

    task automatic modelStep(input logic [9:0] s, input logic [7:0] b, input int due);
        expT        e;
        bit         tok;
        bit         slip;
        logic [1:0] tv;
        tok = 0; slip = 0; tv = 2'b00;
        for (int j = 0; j < 4; j++) begin
            if (s == tokTab[j]) begin
                tok = 1;
                tv  = 2'(j);
            end
        end
        if (mMode == 0) begin
            if (tok) begin mTok++; mIdle = 0; end
            else begin mTok = 0; mIdle++; end
            if (mTok >= LOCK) begin
                mMode = 2; mTok = 0; mIdle = 0;
            end else if (mIdle >= TIMEOUT) begin
                mMode = 1; mTok = 0; mIdle = 0; mWait = 0; slip = 1;
            end
        end else if (mMode == 1) begin
            if (mWait == SLIPWAIT) begin mMode = 0; mWait = 0; end
            else mWait++;
        end else begin
            if (tok) mIdle = 0;
            else mIdle++;
            if (mIdle >= TIMEOUT) begin mMode = 0; mIdle = 0; mTok = 0; end
        end
        e.due = due;
        e.aligned = (mMode == 2);
        e.slip = slip;
        e.de = 1'b0;
        if (mMode != 2) begin
            mData = 8'h00; mCtrl = 2'b00;
        end else if (tok) begin
            mCtrl = tv;
        end else begin
            mData = b; e.de = 1'b1;
        end
        e.data = mData;
        e.ctrl = mCtrl;
        expQ.push_back(e);
    endtask

    task automatic encode(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * int'(qm[8]) + (n0q - n1q);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp += -2 * int'(!qm[8]) + (n1q - n0q);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nTests++;
        if (got !== want) begin
            nFail++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic send(input logic [9:0] s, input logic [7:0] b);
        @(negedge clk);
        sym = s;
        modelStep(s, b, cyc + 2);
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic [9:0] s;
        encode(b, s);
        send(s, b);
    endtask

    task automatic sendTok(input int j);
        send(tokTab[j], 8'h00);
    endtask

    task automatic checkCleared(input string tag);
        check({tag, " data"},    32'(oData),    32'h0);
        check({tag, " ctrl"},    32'(oCtrl),    32'h0);
        check({tag, " de"},      32'(oDe),      32'h0);
        check({tag, " aligned"}, 32'(oAligned), 32'h0);
        check({tag, " bitslip"}, 32'(oBitSlip), 32'h0);
    endtask

    // The symbol held through reset sits in stage 1 and is evaluated on the first edges after release.
    task automatic releaseReset();
        @(negedge clk);
        rst = 1'b0;
        modelStep(HELD, 8'h00, cyc + 1);
        modelStep(HELD, 8'h00, cyc + 2);
    endtask

    initial begin : monitor
        expT e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            while (expQ.size() > 0 && expQ[0].due <= cyc) begin
                e = expQ.pop_front();
                nTests++;
                if ({oData, oCtrl, oDe, oAligned, oBitSlip} !== {e.data, e.ctrl, e.de, e.aligned, e.slip}) begin
                    nFail++;
                    $display("FAIL scoreboard cycle %0d: got data=%h ctrl=%b de=%b aligned=%b slip=%b, want data=%h ctrl=%b de=%b aligned=%b slip=%b",
                             cyc, oData, oCtrl, oDe, oAligned, oBitSlip, e.data, e.ctrl, e.de, e.aligned, e.slip);
                end
            end
        end
    end

    initial begin : stimulus
        bit         bq[$];
        logic [9:0] w;
        int         slips, lastSlip, minGap, extra;

        rst = 1'b1;
        sym = HELD;
        disp = 0;
        modelReset();
        repeat (3) @(negedge clk);
        checkCleared("reset");
        releaseReset();

        for (int i = 0; i < 8; i++) sendTok(0);
        send(10'b0100000000, 8'h00);
        send(10'b0011111111, 8'hFF);
        send(10'b1000000000, 8'hFF);

        for (int b = 0; b < 256; b++) begin
            for (int j = 0; j < 4; j++) sendTok(j);
            sendByte(8'(b));
            sendByte(8'($urandom_range(0, 255)));
        end

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 20) sendTok($urandom_range(0, 3));
            else sendByte(8'($urandom_range(0, 255)));
        end

        // Lock loss, then a run broken one token short of lock.
        for (int i = 0; i < TIMEOUT; i++) sendByte(8'($urandom_range(0, 255)));
        for (int i = 0; i < 7; i++) sendTok($urandom_range(0, 3));
        sendByte(8'h5A);
        for (int i = 0; i < 8; i++) sendTok($urandom_range(0, 3));
        for (int i = 0; i < 4; i++) sendByte(8'($urandom_range(0, 255)));

        // Lose lock, time out in the hunt, then reset while waiting after the slip.
        for (int i = 0; i < 2 * TIMEOUT + 5; i++) sendByte(8'($urandom_range(0, 255)));
        @(posedge clk);
        #3;
        rst = 1'b1;
        expQ.delete();
        modelReset();
        #1;
        checkCleared("async reset");
        repeat (3) @(negedge clk) sym = HELD;
        checkCleared("held reset");
        releaseReset();

        // Token stream delayed by 3 bits; each slip drops one bit.
        bq = {1'b0, 1'b0, 1'b0};
        slips = 0; lastSlip = -1; minGap = 1 << 30; extra = 0;
        for (int it = 0; it < 6000 && extra < 4; it++) begin
            @(negedge clk);
            if (oBitSlip) begin
                slips++;
                if (lastSlip >= 0 && cyc - lastSlip < minGap) minGap = cyc - lastSlip;
                lastSlip = cyc;
                void'(bq.pop_front());
            end
            while (bq.size() < 10) begin
                w = tokTab[0];
                for (int i = 0; i < 10; i++) bq.push_back(w[i]);
            end
            for (int i = 0; i < 10; i++) w[i] = bq.pop_front();
            sym = w;
            modelStep(w, 8'h00, cyc + 2);
            if (mMode == 2) extra++;
        end
        check("slip count", 32'(slips), 32'd3);
        check("slip spacing ok", 32'(minGap >= TIMEOUT + SLIPWAIT + 1), 32'd1);
        check("locked after slips", 32'(oAligned), 32'd1);

        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 99) < 25) sendTok($urandom_range(0, 3));
            else sendByte(8'($urandom_range(0, 255)));
        end
        for (int j = 0; j < 4; j++) sendTok(j);
        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
